// File: rtl/cic_pkg.sv
// Shared types and helpers for the time-multiplexed CIC comb scheduler.
package cic_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STAGE = 1'b1
    } state_e;

    localparam int unsigned M_MIN = 1;
    localparam int unsigned M_MAX = 2;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cic_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last granted one.
module cic_rr_arb
    import cic_pkg::*;
#(
    parameter  int unsigned CH = 2,
    localparam int unsigned IW = clog2_min1(CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] req,
    input  logic          adv,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] ptr_q;
    int unsigned   cand;

    // Scan starts one past the pointer and wraps, so the pointer itself is checked last.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        for (int unsigned i = 1; i <= CH; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= CH) cand = cand - CH;
            if (!gnt_vld && req[IW'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(cand);
            end
        end
    end

    // Pointer resets to the last channel so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IW'(CH - 1);
        end else if (adv && gnt_vld) begin
            ptr_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/cic_comb_sched.sv
// Shared-subtractor comb section for CH channels x N stages with per-channel delay state.
module cic_comb_sched
    import cic_pkg::*;
#(
    parameter  int unsigned CH   = 2,
    parameter  int unsigned N    = 3,
    parameter  int unsigned M    = 1,
    parameter  int unsigned BOUT = 32,
    localparam int unsigned CW   = clog2_min1(CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CH*BOUT-1:0] din,
    input  logic [CH-1:0]      din_vld,
    output logic [BOUT-1:0]    dout,
    output logic [CW-1:0]      dout_ch,
    output logic               dout_vld,
    output logic               busy,
    output logic [CH-1:0]      ovf
);

    localparam int unsigned KW = clog2_min1(N);

    if (M < M_MIN || M > M_MAX) begin : g_bad_m
        $error("cic_comb_sched: differential delay M must be 1 or 2");
    end
    if (CH < 2) begin : g_bad_ch
        $error("cic_comb_sched: CH must be at least 2");
    end

    state_e          state_q, state_d;
    logic [BOUT-1:0] smp_q [CH];
    logic [BOUT-1:0] d_q   [CH][N][M];
    logic [CH-1:0]   pend_q, pend_d, ovf_q, ovf_d, clr_c;
    logic [BOUT-1:0] acc_q, acc_d, dout_q, dout_d, sub_c;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   g_q, g_d, dout_ch_q, dout_ch_d, gnt_idx;
    logic            dout_vld_q, dout_vld_d, busy_q, busy_d, gnt_vld, grant_c, d_we;

    cic_rr_arb #(.CH(CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (pend_q),
        .adv     (grant_c),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_vld) state_d = STAGE;
            STAGE:   if (k_q == KW'(N - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d      = acc_q;
        k_d        = k_q;
        g_d        = g_q;
        dout_d     = dout_q;
        dout_ch_d  = dout_ch_q;
        dout_vld_d = 1'b0;
        d_we       = 1'b0;
        grant_c    = 1'b0;
        sub_c      = acc_q - d_q[g_q][k_q][M-1];
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    grant_c = 1'b1;
                    acc_d   = smp_q[gnt_idx];
                    g_d     = gnt_idx;
                    k_d     = '0;
                end
            end
            STAGE: begin
                acc_d = sub_c;
                d_we  = 1'b1;
                if (k_q == KW'(N - 1)) begin
                    dout_d     = sub_c;
                    dout_ch_d  = g_q;
                    dout_vld_d = 1'b1;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    // A capture beats a same-cycle grant clear; overwrite of a still-pending sample flags ovf.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = '0;
        clr_c  = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            clr_c[c] = grant_c && (gnt_idx == CW'(c));
            if (clr_c[c])   pend_d[c] = 1'b0;
            if (din_vld[c]) pend_d[c] = 1'b1;
            ovf_d[c] = din_vld[c] && pend_q[c] && !clr_c[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            k_q        <= '0;
            g_q        <= '0;
            dout_q     <= '0;
            dout_ch_q  <= '0;
            dout_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            pend_q     <= '0;
            ovf_q      <= '0;
            for (int unsigned c = 0; c < CH; c++) smp_q[c] <= '0;
        end else begin
            acc_q      <= acc_d;
            k_q        <= k_d;
            g_q        <= g_d;
            dout_q     <= dout_d;
            dout_ch_q  <= dout_ch_d;
            dout_vld_q <= dout_vld_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            for (int unsigned c = 0; c < CH; c++) begin
                if (din_vld[c]) smp_q[c] <= din[c*BOUT +: BOUT];
            end
        end
    end

    // Delay line for the active channel/stage; the M=2 tap shifts before the new word lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < CH; c++)
                for (int unsigned k = 0; k < N; k++)
                    for (int unsigned j = 0; j < M; j++)
                        d_q[c][k][j] <= '0;
        end else if (d_we) begin
            if (M > 1) d_q[g_q][k_q][M-1] <= d_q[g_q][k_q][0];
            d_q[g_q][k_q][0] <= acc_q;
        end
    end

    assign dout     = dout_q;
    assign dout_ch  = dout_ch_q;
    assign dout_vld = dout_vld_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_cic_comb_sched.sv
// Directed bench for cic_comb_sched at CH=2, N=3, M=1, BOUT=32.
module tb_cic_comb_sched;

    localparam int unsigned CH   = 2;
    localparam int unsigned BOUT = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [CH*BOUT-1:0] din;
    logic [CH-1:0]      din_vld;
    logic [BOUT-1:0]    dout;
    logic               dout_ch;
    logic               dout_vld;
    logic               busy;
    logic [CH-1:0]      ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] step_exp [4] = '{32'h1, 32'hFFFF_FFFE, 32'h1, 32'h0};

    cic_comb_sched #(.CH(CH), .N(3), .M(1), .BOUT(BOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout),
        .dout_ch  (dout_ch),
        .dout_vld (dout_vld),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        din     = '0;
        din_vld = '0;
        repeat (3) tick();
        check("rst_dout", dout, 32'h0);
        check("rst_vld",  32'(dout_vld), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovf",  32'(ovf), 32'h0);
        rst = 1'b0;
    endtask

    task automatic send(input int ch, input logic [31:0] v, output int t);
        din[ch*BOUT +: BOUT] = v;
        din_vld = CH'(1) << ch;
        t = cyc;
        tick();
        din_vld = '0;
    endtask

    task automatic wait_out(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (dout_vld) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    // Checks arrival cycle relative to t, data and channel, then steps past the strobe.
    task automatic expect_out(input string tag, input int t, input int lat,
                              input logic [31:0] val, input int ch);
        int at;
        wait_out(14, at);
        check({tag, "_lat"}, 32'(at - t), 32'(lat));
        check({tag, "_dat"}, dout, val);
        check({tag, "_ch"},  32'(dout_ch), 32'(ch));
        tick();
    endtask

    task automatic count_vld(input string tag, input int cycles);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (dout_vld) n++;
            tick();
        end
        check(tag, 32'(n), 32'h0);
    endtask

    initial begin
        int t;
        rst     = 1'b1;
        din     = '0;
        din_vld = '0;

        do_reset();

        // Step response on ch0, one sample every 8 cycles.
        for (int i = 0; i < 4; i++) begin
            send(0, 32'h1, t);
            expect_out($sformatf("step%0d", i), t, 5, step_exp[i], 0);
            while (cyc < t + 8) tick();
        end

        // Simultaneous arrivals: ch0 first, ch1 after one service slot plus an idle cycle.
        do_reset();
        din     = {32'd7, 32'd5};
        din_vld = 2'b11;
        t       = cyc;
        tick();
        din_vld = '0;
        check("sim_busy_t1", 32'(busy), 32'h0);
        tick();
        check("sim_busy_t2", 32'(busy), 32'h1);
        expect_out("sim_a0", t, 5, 32'd5, 0);
        expect_out("sim_a1", t, 9, 32'd7, 1);

        // Second equal sample into a 3-stage comb yields -2x.
        din     = {32'd7, 32'd5};
        din_vld = 2'b11;
        t       = cyc;
        tick();
        din_vld = '0;
        expect_out("sim_b0", t, 5, 32'hFFFF_FFF6, 0);
        expect_out("sim_b1", t, 9, 32'hFFFF_FFF2, 1);

        // Overwrite of a pending ch1 sample.
        do_reset();
        din     = {32'd4, 32'd2};
        din_vld = 2'b11;
        t       = cyc;
        tick();
        din_vld = '0;
        tick();
        din[BOUT +: BOUT] = 32'd9;
        din_vld = 2'b10;
        check("ovf_pre", 32'(ovf), 32'h0);
        tick();
        din_vld = '0;
        check("ovf_pulse", 32'(ovf), 32'h2);
        tick();
        check("ovf_post", 32'(ovf), 32'h0);
        expect_out("ovf_ch0", t, 5, 32'd2, 0);
        expect_out("ovf_ch1", t, 9, 32'd9, 1);
        count_vld("ovf_no_2nd", 12);
        check("ovf_idle", 32'(busy), 32'h0);

        // Modulo arithmetic across the signed boundary.
        do_reset();
        send(0, 32'h7FFF_FFFF, t);
        expect_out("wrap0", t, 5, 32'h7FFF_FFFF, 0);
        send(0, 32'h8000_0000, t);
        expect_out("wrap1", t, 5, 32'h0000_0003, 0);

        // Reset while stage k=1 is in flight drops the sample and clears history.
        do_reset();
        send(0, 32'h1, t);
        expect_out("mr_pre", t, 5, 32'h1, 0);
        send(0, 32'h5, t);
        repeat (2) tick();
        check("mr_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_busy0", 32'(busy), 32'h0);
        check("mr_vld0",  32'(dout_vld), 32'h0);
        check("mr_dout0", dout, 32'h0);
        count_vld("mr_no_out", 10);
        send(0, 32'h1, t);
        expect_out("mr_post", t, 5, 32'h1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
